// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 slave-side bus bundle for the memory responder: AW/W/B write path and AR/R read path.
// Signal names keep the s_axi_ prefix so they line up with the kernel's host-memory port.
interface axi_slave_mem_responder_if #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 1024
);
    logic [ID_WIDTH-1:0]     s_axi_awid;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic [2:0]              s_axi_awsize;
    logic [1:0]              s_axi_awburst;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wlast;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [ID_WIDTH-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ID_WIDTH-1:0]     s_axi_arid;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic [2:0]              s_axi_arsize;
    logic [1:0]              s_axi_arburst;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ID_WIDTH-1:0]     s_axi_rid;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface

// File: rtl/axi_slave_mem_responder.sv
// AXI4 memory slave: INCR bursts against a small line memory, independent read and write FSMs.
// Non-INCR or non-full-width bursts are handshaken in full but answered with SLVERR.
module axi_slave_mem_responder #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 1024,
    parameter int MEM_AW     = 6
) (
    input logic clk,
    input logic reset,
    axi_slave_mem_responder_if.slave axi
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam int DEPTH  = 1 << MEM_AW;

    localparam logic [2:0] FULL_SIZE    = 3'(NB_LOG);
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write path state
    logic [1:0]          w_state_q, w_state_d;
    logic                awready_q, awready_d;
    logic                wready_q,  wready_d;
    logic                bvalid_q,  bvalid_d;
    logic [ID_WIDTH-1:0] bid_q,     bid_d;
    logic [1:0]          bresp_q,   bresp_d;
    logic [ID_WIDTH-1:0] w_id_q,    w_id_d;
    logic [MEM_AW-1:0]   w_idx_q,   w_idx_d;
    logic [7:0]          w_len_q,   w_len_d;
    logic [8:0]          w_beat_q,  w_beat_d;
    logic                w_legal_q, w_legal_d;
    logic                w_err_q,   w_err_d;

    // Read path state
    logic [1:0]            r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [ID_WIDTH-1:0]   rid_q,     rid_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [MEM_AW-1:0]     r_idx_q,   r_idx_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [8:0]            r_beat_q,  r_beat_d;
    logic                  r_legal_q, r_legal_d;

    logic w_hs_s;
    logic w_last_beat_s;
    logic unused_addr_s;

    assign w_hs_s        = axi.s_axi_wvalid & wready_q;
    assign w_last_beat_s = (w_beat_q == {1'b0, w_len_q});
    assign unused_addr_s = ^{axi.s_axi_awaddr[NB_LOG-1:0], axi.s_axi_awaddr[ADDR_WIDTH-1:NB_LOG+MEM_AW],
                             axi.s_axi_araddr[NB_LOG-1:0], axi.s_axi_araddr[ADDR_WIDTH-1:NB_LOG+MEM_AW]};

    // Write FSM next-state: AW latch, W beats with sticky wlast check, then hold B until accepted
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_legal_d = w_legal_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (axi.s_axi_awvalid && awready_q) begin
                    w_id_d    = axi.s_axi_awid;
                    w_idx_d   = axi.s_axi_awaddr[NB_LOG +: MEM_AW];
                    w_len_d   = axi.s_axi_awlen;
                    w_legal_d = (axi.s_axi_awburst == BURST_INCR) && (axi.s_axi_awsize == FULL_SIZE);
                    w_beat_d  = 9'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s) begin
                    w_err_d  = w_err_q | (axi.s_axi_wlast != w_last_beat_s);
                    w_idx_d  = w_idx_q + MEM_AW'(1'b1);
                    w_beat_d = w_beat_q + 9'd1;
                    if (w_last_beat_s) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_d || !w_legal_q) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (axi.s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Write FSM registers
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_WIDTH{1'b0}};
            bresp_q   <= 2'b00;
            w_id_q    <= {ID_WIDTH{1'b0}};
            w_idx_q   <= {MEM_AW{1'b0}};
            w_len_q   <= 8'd0;
            w_beat_q  <= 9'd0;
            w_legal_q <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_legal_q <= w_legal_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-masked line write; contents survive reset, and a same-cycle fetch sees the old line
    always_ff @(posedge clk) begin
        if (!reset && (w_state_q == W_DATA) && w_hs_s && w_legal_q) begin
            for (int b = 0; b < NB; b++) begin
                if (axi.s_axi_wstrb[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= axi.s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next-state: one fetch cycle per beat, R held stable until accepted
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_legal_d = r_legal_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi.s_axi_arvalid && arready_q) begin
                    r_id_d    = axi.s_axi_arid;
                    r_idx_d   = axi.s_axi_araddr[NB_LOG +: MEM_AW];
                    r_len_d   = axi.s_axi_arlen;
                    r_legal_d = (axi.s_axi_arburst == BURST_INCR) && (axi.s_axi_arsize == FULL_SIZE);
                    r_beat_d  = 9'd0;
                    arready_d = 1'b0;
                    r_state_d = R_FETCH;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_FETCH: begin
                rvalid_d  = 1'b1;
                rid_d     = r_id_q;
                rlast_d   = (r_beat_q == {1'b0, r_len_q});
                rresp_d   = r_legal_q ? RESP_OKAY : RESP_SLVERR;
                rdata_d   = r_legal_q ? mem_q[r_idx_q] : {DATA_WIDTH{1'b0}};
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi.s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + MEM_AW'(1'b1);
                        r_beat_d  = r_beat_q + 9'd1;
                        r_state_d = R_FETCH;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= {ID_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            r_id_q    <= {ID_WIDTH{1'b0}};
            r_idx_q   <= {MEM_AW{1'b0}};
            r_len_q   <= 8'd0;
            r_beat_q  <= 9'd0;
            r_legal_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_legal_q <= r_legal_d;
        end
    end

    assign axi.s_axi_awready = awready_q;
    assign axi.s_axi_wready  = wready_q;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bid     = bid_q;
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_arready = arready_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rlast   = rlast_q;
    assign axi.s_axi_rid     = rid_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_rdata   = rdata_q;
endmodule

// File: doc/axi_slave_mem_responder.md
Name: axi_slave_mem_responder

Overview:
Synthesizable AXI4 memory slave that answers the host-memory master port of a single-engine kernel. It is used in block-level simulation and loopback builds in place of the OCACCEL host path. It serves INCR read and write bursts from a small on-chip line memory, with independent read and write paths.

Parameters:
ID_WIDTH, 5, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 1024, data width; bytes per beat NB = DATA_WIDTH/8
MEM_AW, 6, log2 of memory depth in lines (64 lines)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  beat size
s_axi_awburst  in  2  burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  NB  byte strobes
s_axi_wlast  in  1  last beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  OKAY=0 / SLVERR=2
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  OKAY/SLVERR
s_axi_rlast  out  1  last beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset (sync, high): awready=1, arready=1; wready, bvalid, rvalid and rlast = 0; bid, bresp, rid, rresp and rdata = 0. Both FSMs go to IDLE. Memory contents are kept. Reset mid-burst abandons the burst; all valids are low the cycle after reset is sampled.
- Line index = addr[log2(NB) +: MEM_AW], incremented by 1 per beat. The index wraps modulo 2^MEM_AW. The low address bits are ignored.
- Legal burst: burst==INCR (1) and size==log2(NB). Any other burst is still fully handshaken with exactly len+1 beats, but it does not touch memory (writes) or returns zero data (reads), and responds SLVERR.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch id/index/len/legal and go to W_DATA.
  - W_DATA (awready=0, wready=1): each W handshake writes the bytes whose wstrb bit is set, then increments the index and beat count.
  - wlast must be 1 exactly on beat len. Any mismatch sets a sticky err; the burst still ends on beat len.
  - After the last beat go to W_RESP: bvalid=1, bid=latched id, bresp=SLVERR if err or illegal, else OKAY. Hold until bready, then go to W_IDLE with awready=1 on the next cycle.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch and go to R_FETCH. The memory read is issued in R_FETCH.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). rdata and rresp are held stable until rready.
  - On handshake, go to R_IDLE if last, else to R_FETCH with index+1.
  - First rvalid appears 2 cycles after the AR handshake; throughput is 1 beat per 2 cycles minimum.
- Read and write paths run concurrently. If a read fetch and a write beat hit the same line in the same cycle, the fetch returns the pre-write data (read-first).
- len=0 is a single beat with wlast/rlast on that beat. len=255 gives 256 beats with a 9-bit beat counter, no overflow.

Test Plan:
- Write burst: AW addr 0x0, len=3, INCR, size=7, all strobes set, data k=0..3 = 0x11*(k+1); then AR to the same address, len=3 -> bresp=0; R returns the 4 words in order, rlast on beat 3, first rvalid 2 cycles after AR handshake.
- Strobes: write line 5 with 0xFF.., then write wstrb=0x1 with data 0x00 -> read of line 5 returns 0xFF..FF00.
- Wrap: AW at line 62 (addr 62*128), len=3 -> beats land in lines 62, 63, 0, 1; a read of line 0 returns beat 2.
- Errors: awburst=FIXED -> 1 beat accepted, memory unchanged, bresp=2. Early wlast on beat 1 of len=3 -> 4 beats accepted, bresp=2. arsize=2 -> rresp=2, rdata=0.
- Backpressure/ID: hold bready and rready low for 10 cycles -> bvalid/rvalid, bid/rid (0x1A) and data stay stable. Concurrent read/write to the same line -> read-first data returned.
- Reset mid-burst: assert reset after 2 of 4 W beats -> next cycle awready=1, wready=0, bvalid=0; a new burst then completes normally.
